// File: rtl/mul_f.sv
// mul_f -- IEEE-754 binary32 multiplier, s = a * b, round-to-nearest-even.
//
// Two-stage pipeline:
//   stage 1 : sign XOR, biased exponent sum, 24x24 significand product,
//             special-operand classification (NaN / infinity / zero).
//   stage 2 : normalise, round (RNE), overflow/underflow, special override,
//             pack into the registered output s.
// Subnormal operands are flushed to zero; subnormal results flush to signed zero.
//
// Ports
//   clk       in   1   clock, all state on rising edge
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   a/b valid this cycle
//   a         in   32  operand A (binary32)
//   b         in   32  operand B (binary32)
//   s         out  32  product (binary32), registered, holds when no result
//   out_valid out  1   s holds the result of operands sampled 2 cycles earlier
module mul_f (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        out_valid
);

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // ---------------- stage 1 (combinational) ----------------
  logic [7:0]  exp_a, exp_b;
  logic [23:0] man_a, man_b;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [9:0]  exp_sum;
  logic [47:0] prod;

  assign exp_a  = a[30:23];
  assign exp_b  = b[30:23];
  assign man_a  = {1'b1, a[22:0]};
  assign man_b  = {1'b1, b[22:0]};
  // exp == 0 covers both true zero and subnormals (flush-to-zero)
  assign zero_a = (exp_a == 8'd0);
  assign zero_b = (exp_b == 8'd0);
  assign inf_a  = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
  assign inf_b  = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
  assign nan_a  = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
  assign nan_b  = (exp_b == 8'hFF) && (b[22:0] != 23'd0);
  // 10-bit two's complement: range -125..381 fits comfortably
  assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;
  assign prod    = {24'd0, man_a} * {24'd0, man_b};

  // ---------------- stage 1 registers ----------------
  logic        valid_reg;
  logic        sign_reg;
  logic [9:0]  exp_reg;
  logic [47:0] prod_reg;
  logic        nan_reg, inf_reg, zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      sign_reg  <= 1'b0;
      exp_reg   <= 10'd0;
      prod_reg  <= 48'd0;
      nan_reg   <= 1'b0;
      inf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      sign_reg  <= a[31] ^ b[31];
      exp_reg   <= exp_sum;
      prod_reg  <= prod;
      nan_reg   <= nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
      inf_reg   <= inf_a | inf_b;
      zero_reg  <= zero_a | zero_b;
    end
  end

  // ---------------- stage 2 (combinational) ----------------
  logic [9:0]  exp_norm;
  logic [22:0] frac_trunc;
  logic        guard, sticky, round_up;
  logic [23:0] frac_rnd;
  logic [9:0]  exp_rnd;
  logic        ssign;
  logic [7:0]  sexp;
  logic [22:0] smant;

  always_comb begin
    // product of two [1,2) significands lies in [1,4): bit47 selects the shift
    if (prod_reg[47]) begin
      exp_norm   = exp_reg + 10'd1;
      frac_trunc = prod_reg[46:24];
      guard      = prod_reg[23];
      sticky     = |prod_reg[22:0];
    end else begin
      exp_norm   = exp_reg;
      frac_trunc = prod_reg[45:23];
      guard      = prod_reg[22];
      sticky     = |prod_reg[21:0];
    end
    round_up = guard & (sticky | frac_trunc[0]);
    // carry out of the fraction means significand became 2.0: fraction wraps to 0, exp+1
    frac_rnd = {1'b0, frac_trunc} + {23'd0, round_up};
    exp_rnd  = exp_norm + {9'd0, frac_rnd[23]};

    ssign = sign_reg;
    sexp  = exp_rnd[7:0];
    smant = frac_rnd[22:0];
    if (nan_reg) begin
      ssign = CANON_NAN[31];
      sexp  = CANON_NAN[30:23];
      smant = CANON_NAN[22:0];
    end else if (inf_reg) begin
      sexp  = 8'hFF;
      smant = 23'd0;
    end else if (zero_reg) begin
      sexp  = 8'd0;
      smant = 23'd0;
    end else if ($signed(exp_rnd) >= $signed(10'd255)) begin
      sexp  = 8'hFF;
      smant = 23'd0;
    end else if ($signed(exp_rnd) <= $signed(10'd0)) begin
      sexp  = 8'd0;
      smant = 23'd0;
    end
  end

  // ---------------- stage 2 registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_reg;
      if (valid_reg) begin
        s <= {ssign, sexp, smant};
      end
    end
  end

endmodule

// File: tb/tb_mul_f.sv
module tb_mul_f;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] s;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mul_f dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .s        (s),
    .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference: significand product, remainder-vs-half rounding.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic   sg;
    int     ex, ey, e, sh;
    bit     zx, zy, ix, iy, nx, ny;
    longint p, q, r, half;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC00000;
    if (ix || iy) return {sg, 8'hFF, 23'd0};
    if (zx || zy) return {sg, 31'd0};
    p = (longint'(x[22:0]) + (longint'(1) << 23)) * (longint'(y[22:0]) + (longint'(1) << 23));
    e = ex + ey - 127;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    r    = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && (q & 1) == 1)) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0) return {sg, 31'd0};
    return {sg, 8'(e), 23'(q)};
  endfunction

  // Drive one operand pair (or an idle cycle) and record the expectation.
  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    a        = x;
    b        = y;
    if (v) exp_q.push_back(ref_mul(x, y));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 32'h3F800000, 32'h40A00000);
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (s !== 32'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: s=%h out_valid=%b required s=00000000 out_valid=0", s, out_valid);
    end
    drive(1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    $display("reset: s=%h out_valid=%b", s, out_valid);
  endtask

  task automatic test_vectors;
    logic [31:0] va[8] = '{32'h404CCCCD, 32'h3F800000, 32'hC0A00000, 32'hC0400000,
                           32'h7F800000, 32'h7F000000, 32'h00800000, 32'h80000000};
    logic [31:0] vb[8] = '{32'hBFA66666, 32'h40A00000, 32'h40400000, 32'hC0666666,
                           32'h00000000, 32'h7F000000, 32'h00800000, 32'h3F800000};
    logic [31:0] vs[8] = '{32'hC0851EB8, 32'h40A00000, 32'hC1700000, 32'h412CCCCC,
                           32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
    int idx = 0;
    // each vector separated by an idle cycle; fixed spec expectations checked in order
    for (int k = 0; k < 8 * 2 + 4; k++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (idx >= 8) begin
          failures++;
          $display("FAIL spec_vec_extra: unexpected out_valid s=%h", s);
        end else begin
          if (s !== vs[idx]) begin
            failures++;
            $display("FAIL spec_vec%0d: a=%h b=%h s=%h required %h", idx, va[idx], vb[idx], s, vs[idx]);
          end else begin
            $display("spec_vec%0d: a=%h b=%h s=%h", idx, va[idx], vb[idx], s);
          end
          idx++;
        end
      end
      if (k < 16 && (k % 2) == 0) drive(1'b1, va[k/2], vb[k/2]);
      else drive(1'b0, 32'd0, 32'd0);
    end
    exp_q.delete();
    checks++;
    if (idx != 8) begin
      failures++;
      $display("FAIL spec_vec_count: results=%0d required 8", idx);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va[4] = '{32'h404CCCCD, 32'h3F800000, 32'hC0A00000, 32'hC0400000};
    logic [31:0] vb[4] = '{32'hBFA66666, 32'h40A00000, 32'h40400000, 32'hC0666666};
    logic [31:0] got;
    logic        want_v;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, va[k], vb[k]);
      else drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      // drive happens in cycle 0; results expected on cycles 2..5
      want_v = (k >= 1 && k <= 4);
      checks++;
      if (out_valid !== want_v) begin
        failures++;
        $display("FAIL b2b_valid cycle%0d: out_valid=%b required %b", k + 1, out_valid, want_v);
      end
      if (out_valid && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        checks++;
        if (s !== got) begin
          failures++;
          $display("FAIL b2b_data cycle%0d: s=%h required %h", k + 1, s, got);
        end else begin
          $display("b2b cycle%0d: s=%h", k + 1, s);
        end
      end
    end
    checks++;
    if (s !== 32'h412CCCCC || out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_hold: s=%h out_valid=%b pending=%0d required s=412ccccc out_valid=0 pending=0",
               s, out_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [31:0] x, y, got;
    int n = 0;
    for (int k = 0; k < 420; k++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra: unexpected out_valid s=%h", s);
        end else begin
          got = exp_q.pop_front();
          if (s !== got) begin
            failures++;
            $display("FAIL rand%0d: s=%h required %h", n, s, got);
          end else begin
            $display("rand%0d: s=%h", n, s);
          end
          n++;
        end
      end
      if (k < 400 && $urandom_range(0, 3) != 0) begin
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 9))
          0: x[30:23] = 8'hFF;
          1: y[30:23] = 8'h00;
          2: begin x[30:23] = 8'(190 + $urandom_range(0, 60)); y[30:23] = 8'(120 + $urandom_range(0, 70)); end
          3: begin x[30:23] = 8'($urandom_range(1, 60)); y[30:23] = 8'($urandom_range(1, 80)); end
          default: begin x[30:23] = 8'($urandom_range(70, 180)); y[30:23] = 8'($urandom_range(70, 180)); end
        endcase
        drive(1'b1, x, y);
      end else begin
        drive(1'b0, 32'd0, 32'd0);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_drain: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'h404CCCCD, 32'hBFA66666);
    @(negedge clk);
    drive(1'b1, 32'h3F800000, 32'h40A00000);
    @(negedge clk);
    drive(1'b1, 32'hC0A00000, 32'h40400000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 32'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: s=%h out_valid=%b required s=00000000 out_valid=0", s, out_valid);
    end else begin
      $display("reset_mid: s=%h out_valid=%b", s, out_valid);
    end
    exp_q.delete();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hC0A00000, 32'h40400000);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_early: out_valid=%b required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || s !== 32'hC1700000) begin
      failures++;
      $display("FAIL post_reset_first: out_valid=%b s=%h required out_valid=1 s=c1700000", out_valid, s);
    end else begin
      $display("post_reset_first: s=%h", s);
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
